// File: rtl/fltr_sched_task_2_if.sv
// Requester-side bus of the shared bit-filter scheduler.
//   req      per-requester request level
//   frame    packed frames, frame k = frame[k*LEN +: LEN]
//   gnt      one-hot grant of the requester being served
//   busy     scheduler is running a transaction
//   done     one-cycle completion pulse
//   done_id  index of the served requester (valid with done)
//   result   captured filter output, first captured bit in MSB
// master: the requester side. slave: the scheduler.
interface fltr_sched_task_2_if #(
  parameter int N   = 2,
  parameter int LEN = 24
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req;
  logic [N*LEN-1:0] frame;
  logic [N-1:0]     gnt;
  logic             busy;
  logic             done;
  logic [IDW-1:0]   done_id;
  logic [LEN-1:0]   result;

  modport master (output req, frame, input gnt, busy, done, done_id, result);
  modport slave  (input req, frame, output gnt, busy, done, done_id, result);
endinterface

// File: rtl/fltr_sched_task_2.sv
// Round-robin sequencer for one shared serial bit filter.
// One requester is granted at a time. The filter is held in reset for CLR_CYC
// cycles, then the frame is streamed MSB-first on flt_in. LEN output bits are
// captured from flt_out, starting FLT_LAT cycles after the first input bit,
// and are returned on result together with a one-cycle done pulse.
// Ports:
//   clk      clock, all logic on posedge
//   reset    synchronous active-low reset
//   bus      requester bus (slave side): req/frame in, gnt/busy/done/done_id/result out
//   flt_rst  active-high reset to the filter
//   flt_in   serial bit to the filter
//   flt_out  serial bit from the filter
module fltr_sched_task_2 #(
  parameter int N       = 2,
  parameter int LEN     = 24,
  parameter int FLT_LAT = 3,
  parameter int CLR_CYC = 2
) (
  input  logic               clk,
  input  logic               reset,
  fltr_sched_task_2_if.slave bus,
  output logic               flt_rst,
  output logic               flt_in,
  input  logic               flt_out
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(LEN + FLT_LAT + CLR_CYC + 1);

  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] FEED_LAST = CW'(LEN - 1);
  localparam logic [CW-1:0] DRN_LAST  = CW'(FLT_LAT - 1);
  localparam logic [CW-1:0] LAT       = CW'(FLT_LAT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]     state;
  logic [CW-1:0]  cnt;    // cycles spent in the current state
  logic [CW-1:0]  pos;    // cycles since the first FEED cycle
  logic [LEN-1:0] sr;     // frame shift register, MSB drives flt_in
  logic [IDW-1:0] rr;     // highest-priority requester
  logic [IDW-1:0] pick;
  logic           hit;
  logic [LEN-1:0] frm_sel;
  logic           streaming, cap;

  // First requester at or above rr; if none, wrap to the lowest set bit.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    for (int j = 0; j < N; j++)
      if (!hit && bus.req[j] && IDW'(j) >= rr) begin
        hit  = 1'b1;
        pick = IDW'(j);
      end
    for (int j = 0; j < N; j++)
      if (!hit && bus.req[j]) begin
        hit  = 1'b1;
        pick = IDW'(j);
      end
  end

  always_comb begin
    frm_sel = '0;
    for (int j = 0; j < N; j++)
      if (pick == IDW'(j)) frm_sel = bus.frame[j*LEN +: LEN];
  end

  assign streaming = (state == S_FEED) || (state == S_DRAIN);
  // Capture window is pos in [FLT_LAT, LEN+FLT_LAT-1]: exactly LEN bits.
  assign cap       = streaming && (pos >= LAT);
  assign flt_rst   = !streaming;
  // sr is not shifted on the last FEED cycle, so during DRAIN its MSB is the
  // frame LSB and flt_in simply holds it.
  assign flt_in    = streaming ? sr[LEN-1] : 1'b0;
  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pos         <= '0;
      sr          <= '0;
      rr          <= '0;
      bus.gnt     <= '0;
      bus.done_id <= '0;
      bus.result  <= '0;
    end else begin
      if (cap) bus.result <= {bus.result[LEN-2:0], flt_out};
      case (state)
        S_IDLE: if (hit) begin
          sr          <= frm_sel;
          bus.done_id <= pick;
          bus.gnt     <= N'(1) << pick;
          rr          <= (pick == IDW'(N - 1)) ? '0 : pick + IDW'(1);
          cnt         <= '0;
          state       <= S_CLEAR;
        end
        S_CLEAR: begin
          if (cnt == CLR_LAST) begin
            cnt   <= '0;
            pos   <= '0;
            state <= S_FEED;
          end else cnt <= cnt + CW'(1);
        end
        S_FEED: begin
          pos <= pos + CW'(1);
          if (cnt == FEED_LAST) begin
            cnt   <= '0;
            state <= (FLT_LAT == 0) ? S_DONE : S_DRAIN;
          end else begin
            cnt <= cnt + CW'(1);
            sr  <= {sr[LEN-2:0], 1'b0};
          end
        end
        S_DRAIN: begin
          pos <= pos + CW'(1);
          if (cnt == DRN_LAST) begin
            cnt   <= '0;
            state <= S_DONE;
          end else cnt <= cnt + CW'(1);
        end
        S_DONE: begin
          bus.gnt <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fltr_sched_task_2.sv
// Bench for fltr_sched_task_2 (N=2, LEN=24, FLT_LAT=3, CLR_CYC=2).
// The filter is a 3-cycle loopback, optionally inverting, so every result is
// the served frame (or its complement).
module tb_fltr_sched_task_2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flt_rst, flt_in, flt_out;
  logic inv = 1'b0;
  logic [2:0] dl;
  int pass_cnt = 0, tot_cnt = 0;
  int rr_m = 0;  // round-robin pointer of the reference model

  always #5 clk = ~clk;

  fltr_sched_task_2_if #(.N(2), .LEN(24)) bus ();

  fltr_sched_task_2 #(.N(2), .LEN(24), .FLT_LAT(3), .CLR_CYC(2)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .flt_rst(flt_rst), .flt_in(flt_in), .flt_out(flt_out)
  );

  always_ff @(posedge clk) dl <= {dl[1:0], flt_in};
  assign flt_out = dl[2] ^ inv;

  typedef struct {
    logic [1:0]  r;
    logic [23:0] f0;
    logic [23:0] f1;
    int          id;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int pick(input logic [1:0] r, input int rr);
    for (int i = 0; i < 2; i++)
      if (r[(rr + i) % 2]) return (rr + i) % 2;
    return 0;
  endfunction

  // Called at a negedge while the DUT is idle. Requests, waits for the grant,
  // optionally disturbs req/frame at scr_at cycles after grant, and checks
  // the streamed bits, latency and returned result.
  task automatic do_txn(input string nm, input logic [1:0] r, input logic [23:0] f0,
                        input logic [23:0] f1, input int exp_id, input bit keep, input int scr_at);
    int n;
    logic [23:0] ef, er, strm;
    ef = (exp_id == 1) ? f1 : f0;
    er = ef ^ {24{inv}};
    bus.req = r;
    bus.frame = {f1, f0};
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt == 2'b00 && n < 8);
    chk({nm, " gnt"}, 32'(bus.gnt), 32'(2'b01 << exp_id));
    rr_m = (exp_id + 1) % 2;
    n = 0;
    strm = '0;
    while (!bus.done && n < 60) begin
      if (n == scr_at) begin
        bus.frame = ~{f0, f1};
        if (!keep) bus.req = 2'b00;
      end
      @(negedge clk);
      n++;
      if (n >= 2 && n <= 25) strm = {strm[22:0], flt_in};
    end
    chk({nm, " latency"}, 32'(n), 32'd29);
    chk({nm, " stream"}, 32'(strm), 32'(ef));
    chk({nm, " done_id"}, 32'(bus.done_id), 32'(exp_id));
    chk({nm, " result"}, 32'(bus.result), 32'(er));
    chk({nm, " gnt@done"}, 32'({bus.gnt, bus.busy, flt_rst}), 32'({2'b01 << exp_id, 2'b11}));
    @(negedge clk);
    chk({nm, " idle"}, 32'({bus.gnt, bus.busy, bus.done}), 32'd0);
  endtask

  initial begin
    int n;
    tbl[0] = '{2'b01, 24'h72FC60, 24'h000000, 0};
    tbl[1] = '{2'b10, 24'h000000, 24'h0F0F0F, 1};
    tbl[2] = '{2'b11, 24'hAAAAAA, 24'h123456, 0};
    tbl[3] = '{2'b11, 24'h555555, 24'h123456, 1};
    tbl[4] = '{2'b10, 24'h000000, 24'hFFFFFF, 1};
    tbl[5] = '{2'b11, 24'h000001, 24'h800000, 0};

    // Reset held with requests pending.
    bus.req = 2'b11;
    bus.frame = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst outs", 32'({bus.gnt, bus.busy, bus.done, flt_rst, flt_in}), 32'b00_0_0_1_0);
      chk("rst regs", 32'({bus.done_id, bus.result}), 32'd0);
    end
    bus.req = 2'b00;
    reset = 1'b1;
    rr_m = 0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      do_txn($sformatf("tbl%0d", i), tbl[i].r, tbl[i].f0, tbl[i].f1, tbl[i].id, 1'b0, 0);

    // Reset pulse in the middle of FEED aborts the transaction.
    bus.req = 2'b11;
    bus.frame = {24'h0F0F0F, 24'hAAAAAA};
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt == 2'b00 && n < 8);
    chk("abort gnt", 32'(bus.gnt), 32'(2'b01 << pick(2'b11, rr_m)));
    repeat (7) @(negedge clk);
    chk("abort busy", 32'({bus.busy, flt_rst}), 32'b10);
    reset = 1'b0;
    @(negedge clk);
    chk("abort idle", 32'({bus.gnt, bus.busy, bus.done, flt_rst, flt_in}), 32'b00_0_0_1_0);
    reset = 1'b1;
    rr_m = 0;

    // Both held: strict alternation starting from requester 0.
    for (int i = 0; i < 4; i++)
      do_txn($sformatf("alt%0d", i), 2'b11, 24'hAAAAAA, 24'h0F0F0F, i % 2, 1'b1, 10);

    // Request dropped and frame changed after 5 FEED cycles.
    do_txn("drop", 2'b10, 24'h000000, 24'hC3A5F0, pick(2'b10, rr_m), 1'b0, 7);

    // Random traffic against the model, some with an inverting filter.
    for (int i = 0; i < 20; i++) begin
      logic [1:0] r;
      logic [23:0] f0, f1;
      r = 2'($urandom_range(1, 3));
      f0 = 24'($urandom);
      f1 = 24'($urandom);
      inv = 1'($urandom_range(0, 1));
      do_txn($sformatf("rnd%0d", i), r, f0, f1, pick(r, rr_m),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 25)));
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
